alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 The block SHALL have parameter OP_W, default 4, meaning ALU operation code width.
REQ-003 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqN_valid  input  1  (N=0,1) requester N has an operation pending.
REQ-007 reqN_ready  output  1  (N=0,1) requester N granted this cycle; operands accepted.
REQ-008 reqN_op  input  OP_W  requester N operation code.
REQ-009 reqN_a, reqN_b  input  DATA_W  requester N operands.
REQ-010 reqN_shamt  input  5  requester N shift amount.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_id  output  1  index of requester owning the response.
REQ-014 rsp_result  output  DATA_W; rsp_zero  output  1  captured ALU result and zero flag.
REQ-015 alu_op  output  OP_W; alu_a, alu_b  output  DATA_W; alu_shamt  output  5  drive the shared ALU.
REQ-016 alu_result  input  DATA_W; alu_zero  input  1  combinational ALU outputs.

Function
REQ-017 The block SHALL implement states IDLE, EXEC, RESP.
REQ-018 IDLE: if any reqN_valid, assert reqN_ready for exactly one granted requester, latch its op/a/b/shamt and id at the edge, go EXEC; else stay IDLE.
REQ-019 reqN_ready SHALL be high only in IDLE or in RESP with rsp_ready high, and never for both requesters in one cycle.
REQ-020 EXEC: alu_* SHALL be driven from the latched operand registers; at the edge alu_result/alu_zero SHALL be captured into rsp_result/rsp_zero; go RESP.
REQ-021 alu_* outputs SHALL always come from the operand registers, stable outside grant edges.
REQ-022 RESP: rsp_valid SHALL be high; result, zero and id SHALL hold until rsp_ready.
REQ-023 RESP with rsp_ready and a valid request: grant in the same cycle, go EXEC; with rsp_ready and no request: go IDLE; without rsp_ready: stay RESP, no grant.
REQ-024 Latency: grant cycle N, rsp_valid first high in cycle N+2; peak throughput one operation per 2 cycles.
REQ-025 A requester deasserting valid before ready SHALL receive no grant and no response.
REQ-026 Operation codes SHALL pass through unmodified; the arbiter SHALL NOT decode or reject them.

Reset
REQ-027 Reset SHALL force IDLE, rsp_valid=0, req0_ready=req1_ready=0, rsp_id=0, rsp_result=0, rsp_zero=0, operand registers 0 (alu_op=0, alu_a=alu_b=0, alu_shamt=0).
REQ-028 Reset during EXEC or RESP SHALL discard the operation; no response SHALL be issued for it.
REQ-029 Reset SHALL set the last-grant pointer to 1 so requester 0 wins the first contended grant.

Configuration
REQ-030 With macro ALU_ARB_RR_EN defined, contended grants SHALL alternate (winner = requester not granted last); the pointer updates on every grant.
REQ-031 Without ALU_ARB_RR_EN, requester 0 SHALL always win contention and no pointer register SHALL exist.

Structure
REQ-032 Package alu_pkg SHALL hold ALU opcode constants (SLL=0000, SRL=0001, LUI=0010, ADD=0011, SUB=0100, AND=0101, NOR=0111, OR=1000), DATA_W/OP_W defaults and the state encoding.
REQ-033 Grant selection SHALL be one sub-module alu_arb_grant (inputs: two valids, pointer, enable; output: one-hot grant).
REQ-034 The ALU SHALL be instantiated outside this block; the bench SHALL connect a real ALU instance.

Verification
REQ-035 req0 ADD a=5 b=7 alone, rsp_ready=1 -> rsp_valid 2 cycles after grant, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-036 req1 SUB a=9 b=9 -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-037 Both valid continuously, RR enabled, 4 ops -> grant order 0,1,0,1; RR disabled -> 0,0,0,0 and req1_ready never high.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_result/rsp_id stable, no reqN_ready, alu_* unchanged.
REQ-039 Reset asserted in EXEC of req0 SLL b=1 shamt=4 -> next cycle IDLE, rsp_valid=0, no response for that op, all outputs at reset values.
REQ-040 req0 LUI b=0x0000ABCD then RESP+rsp_ready with req1 OR a=0xF0 b=0x0F pending -> rsp 0xABCD0000, same-cycle grant of req1, next rsp 0x000000FF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, width defaults, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;

    // Opcodes understood by the shared ALU. The arbiter never decodes these.
    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU used by the requesters behind alu_arbiter.
// Latency: combinational.
// Backpressure: none.
// Ports: i_op opcode, i_a/i_b operands, i_shamt shift amount, o_result result, o_zero result==0.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [4:0]        i_shamt,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_SLL: o_result = i_b << i_shamt;
            ALU_SRL: o_result = i_b >> i_shamt;
            ALU_LUI: o_result = i_b << 16;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_OR:  o_result = i_a | i_b;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arb_grant.sv
// Two-way grant selector: one-hot grant among valid requesters, fixed or round-robin priority.
// Latency: combinational.
// Backpressure: no grant while i_en is low.
// Ports: i_vld[1:0] request valids, i_last index granted last, i_en grant permitted this cycle,
//        o_grant[1:0] one-hot grant (all zero when nothing is granted).
module alu_arb_grant #(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] i_vld,
    input  logic       i_last,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_vld)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                // Contention: with round-robin the requester not served last wins,
                // otherwise requester 0 always wins.
                2'b11:   o_grant = (RR_EN && !i_last) ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU and returns the captured result to the owner.
// Latency: grant in cycle N, rsp_valid in cycle N+2; at most one operation per 2 cycles.
// Backpressure: rsp_ready low holds the response and blocks all grants.
// Ports: clk/reset (sync, active-high); reqN_valid/ready/op/a/b/shamt per requester (N=0,1);
//        rsp_valid/ready/id/result/zero response channel; alu_op/a/b/shamt drive the ALU,
//        alu_result/alu_zero come back from it combinationally.
// Build option: define ALU_ARB_RR_EN for alternating priority under contention; without it
//        requester 0 always wins and no last-grant pointer is built.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req1_shamt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_en;
    logic [1:0]        w_grant;
    logic              w_take;
    logic              w_last;

    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [4:0]        r_shamt;
    logic              r_id;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;

    // Grants happen only in IDLE or when the pending response is being consumed.
    // Reset masks grants so no requester sees a handshake that the reset would discard.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_en = !reset;
                if (req0_valid || req1_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_grant_en  = !reset;
                    w_state_nxt = (req0_valid || req1_valid) ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // Index of the most recent grant; 1 after reset so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_take) begin
            r_last <= w_grant[1];
        end
    end

    assign w_last = r_last;

    alu_arb_grant #(.RR_EN(1'b1)) u_grant (
        .i_vld   ({req1_valid, req0_valid}),
        .i_last  (w_last),
        .i_en    (w_grant_en),
        .o_grant (w_grant)
    );
`else
    assign w_last = 1'b1;

    alu_arb_grant #(.RR_EN(1'b0)) u_grant (
        .i_vld   ({req1_valid, req0_valid}),
        .i_last  (w_last),
        .i_en    (w_grant_en),
        .o_grant (w_grant)
    );
`endif

    assign w_take     = |w_grant;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Operand registers only move on a grant edge, so the ALU inputs stay
            // stable through EXEC and the whole RESP hold.
            if (w_take) begin
                r_op    <= w_grant[1] ? req1_op    : req0_op;
                r_a     <= w_grant[1] ? req1_a     : req0_a;
                r_b     <= w_grant[1] ? req1_b     : req0_b;
                r_shamt <= w_grant[1] ? req1_shamt : req0_shamt;
                r_id    <= w_grant[1];
            end
            if (r_state == ST_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
                r_rsp_id     <= r_id;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_shamt = r_shamt;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OW-1:0] req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]    req0_shamt, req1_shamt;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [DW-1:0] rsp_result;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [4:0]    alu_shamt;
    logic          alu_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu #(.DATA_W(DW)) u_alu (
        .i_op(alu_op), .i_a(alu_a), .i_b(alu_b), .i_shamt(alu_shamt),
        .o_result(alu_result), .o_zero(alu_zero)
    );

    task automatic test_reset;
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2; req0_shamt = 5'd3;
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd4; req1_b = 32'd5; req1_shamt = 5'd6;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready got %0b exp 0", req0_ready); else n_pass++;
        n_checks++; if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready got %0b exp 0", req1_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %0b exp 0", rsp_id); else n_pass++;
        n_checks++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result got %0h exp 0", rsp_result); else n_pass++;
        n_checks++; if (rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero got %0b exp 0", rsp_zero); else n_pass++;
        n_checks++; if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_shamt !== 5'd0)
            $display("FAIL reset_alu_regs got op=%0h a=%0h b=%0h sh=%0d exp all 0", alu_op, alu_a, alu_b, alu_shamt);
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_add;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_shamt = 5'd0; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL add_grant got r0=%0b r1=%0b exp 1,0", req0_ready, req1_ready); else n_pass++;
        @(negedge clk); req0_valid = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_exec_rsp_valid got %0b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (alu_op !== ALU_ADD || alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL add_alu_drive got op=%0h a=%0d b=%0d exp 3,5,7", alu_op, alu_a, alu_b); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid got %0b exp 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_result !== 32'd12) $display("FAIL add_result got %0d exp 12", rsp_result); else n_pass++;
        n_checks++; if (rsp_zero !== 1'b0 || rsp_id !== 1'b0) $display("FAIL add_zero_id got z=%0b id=%0b exp 0,0", rsp_zero, rsp_id); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_idle_after got %0b exp 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_sub;
        @(negedge clk);
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd9; req1_b = 32'd9; req1_shamt = 5'd0; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL sub_grant got r0=%0b r1=%0b exp 0,1", req0_ready, req1_ready); else n_pass++;
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0) $display("FAIL sub_result got v=%0b r=%0h exp 1,0", rsp_valid, rsp_result); else n_pass++;
        n_checks++; if (rsp_zero !== 1'b1 || rsp_id !== 1'b1) $display("FAIL sub_zero_id got z=%0b id=%0b exp 1,1", rsp_zero, rsp_id); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        int g = 0;
        int r = 0;
        int gid[4];
        int rid[4];
        logic [DW-1:0] rres[4];
        int exp_id[4];
        bit both_rdy = 0;
        bit r1_seen = 0;
`ifdef ALU_ARB_RR_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && r < 4; cyc++) begin
            @(negedge clk);
            req0_valid = (g < 4); req1_valid = (g < 4);
            #1;
            if (req0_ready && req1_ready) both_rdy = 1;
            if (req1_ready) r1_seen = 1;
            if (req0_ready || req1_ready) begin
                if (g < 4) gid[g] = int'(req1_ready);
                g++;
            end
            if (rsp_valid) begin
                if (r < 4) begin rid[r] = int'(rsp_id); rres[r] = rsp_result; end
                r++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++; if (g != 4 || r != 4) $display("FAIL arb_counts got grants=%0d rsps=%0d exp 4,4", g, r); else n_pass++;
        n_checks++; if (both_rdy) $display("FAIL arb_dual_ready got 1 exp 0"); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (gid[i] != exp_id[i]) $display("FAIL arb_grant%0d got %0d exp %0d", i, gid[i], exp_id[i]); else n_pass++;
            n_checks++; if (rid[i] != exp_id[i] || rres[i] !== ((exp_id[i] == 1) ? 32'd4 : 32'd2))
                $display("FAIL arb_rsp%0d got id=%0d res=%0d exp id=%0d", i, rid[i], rres[i], exp_id[i]);
            else n_pass++;
        end
`ifndef ALU_ARB_RR_EN
        n_checks++; if (r1_seen) $display("FAIL arb_req1_ready_seen got 1 exp 0"); else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_stall;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 32'h0000FF00; req0_b = 32'h00000FF0; rsp_ready = 1'b0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL stall_grant got %0b exp 1", req0_ready); else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_op = ALU_NOR; req1_a = 32'd0; req1_b = 32'd0;
        #1;
        n_checks++; if (req1_ready !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL stall_exec got r1=%0b v=%0b exp 0,0", req1_ready, rsp_valid); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h00000F00 || rsp_id !== 1'b0)
                $display("FAIL stall_hold%0d got v=%0b r=%0h id=%0b exp 1,f00,0", c, rsp_valid, rsp_result, rsp_id);
            else n_pass++;
            n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL stall_ready%0d got %0b%0b exp 00", c, req1_ready, req0_ready); else n_pass++;
            n_checks++; if (alu_op !== ALU_AND || alu_a !== 32'h0000FF00 || alu_b !== 32'h00000FF0)
                $display("FAIL stall_alu%0d got op=%0h a=%0h b=%0h exp 5,ff00,ff0", c, alu_op, alu_a, alu_b);
            else n_pass++;
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL stall_release_grant got %0b exp 1", req1_ready); else n_pass++;
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0 || alu_op !== ALU_NOR) $display("FAIL stall_next_exec got v=%0b op=%0h exp 0,7", rsp_valid, alu_op); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFFFFFF || rsp_zero !== 1'b0 || rsp_id !== 1'b1)
            $display("FAIL stall_next_rsp got v=%0b r=%0h z=%0b id=%0b exp 1,ffffffff,0,1", rsp_valid, rsp_result, rsp_zero, rsp_id);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_withdraw;
        int extra = 0;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'hF; req0_a = 32'd3; req0_b = 32'd4; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL wd_grant got %0b exp 1", req0_ready); else n_pass++;
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b1; #1;
        n_checks++; if (req1_ready !== 1'b0 || alu_op !== 4'hF) $display("FAIL wd_exec got r1=%0b op=%0h exp 0,f", req1_ready, alu_op); else n_pass++;
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL wd_rsp got v=%0b r=%0h z=%0b r1=%0b exp 1,0,1,0", rsp_valid, rsp_result, rsp_zero, req1_ready);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (rsp_valid || req0_ready || req1_ready) extra++;
        end
        n_checks++; if (extra != 0) $display("FAIL wd_no_response got %0d active cycles exp 0", extra); else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = ALU_LUI; req0_a = 32'd0; req0_b = 32'h0000ABCD; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL b2b_grant0 got %0b exp 1", req0_ready); else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_op = ALU_OR; req1_a = 32'h000000F0; req1_b = 32'h0000000F;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_exec0 got %0b exp 0", rsp_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hABCD0000 || rsp_id !== 1'b0)
            $display("FAIL b2b_rsp0 got v=%0b r=%0h id=%0b exp 1,abcd0000,0", rsp_valid, rsp_result, rsp_id);
        else n_pass++;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL b2b_same_cycle_grant got %0b exp 1", req1_ready); else n_pass++;
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'h000000F0) $display("FAIL b2b_exec1 got v=%0b a=%0h exp 0,f0", rsp_valid, alu_a); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h000000FF || rsp_id !== 1'b1)
            $display("FAIL b2b_rsp1 got v=%0b r=%0h id=%0b exp 1,ff,1", rsp_valid, rsp_result, rsp_id);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = ALU_SLL; req0_a = 32'd0; req0_b = 32'd1; req0_shamt = 5'd4; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL rmid_grant got %0b exp 1", req0_ready); else n_pass++;
        @(negedge clk); req0_valid = 1'b0; #1;
        n_checks++; if (alu_shamt !== 5'd4 || alu_b !== 32'd1) $display("FAIL rmid_exec got sh=%0d b=%0h exp 4,1", alu_shamt, alu_b); else n_pass++;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0)
            $display("FAIL rmid_rsp_regs got v=%0b r=%0h id=%0b z=%0b exp 0,0,0,0", rsp_valid, rsp_result, rsp_id, rsp_zero);
        else n_pass++;
        n_checks++; if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_shamt !== 5'd0)
            $display("FAIL rmid_alu_regs got op=%0h a=%0h b=%0h sh=%0d exp all 0", alu_op, alu_a, alu_b, alu_shamt);
        else n_pass++;
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL rmid_ready got %0b%0b exp 00", req1_ready, req0_ready); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL rmid_no_response got %0d rsp cycles exp 0", seen); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
        test_reset();
        test_add();
        test_sub();
        test_arbitration();
        test_stall();
        test_withdraw();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
